// File: rtl/sdrd_deser.sv
// rtl/sdrd_deser.sv - SDRD serial readback deserializer
// Assembles MSB-first frames from the sequencer read window and hands words to the CPU side.
module sdrd_deser #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             br_w,
  input  logic             frame_start,
  input  logic             bit_vld,
  input  logic             sdrd_in,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_rdy,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, word_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [7:0]       gap, gap_nxt;
  logic             complete, to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      gap         <= '0;
      data_out    <= '0;
      data_rdy    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      gap   <= gap_nxt;
      if (complete) begin
        if (!data_rdy || rd_ack) begin
          data_out <= word_nxt;
          data_rdy <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_ack) begin
        data_rdy    <= 1'b0;
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      // A fresh timeout outranks a clearing ack in the same cycle.
      if (to_hit) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    complete  = 1'b0;
    to_hit    = 1'b0;
    word_nxt  = {shreg[WIDTH-2:0], sdrd_in};
    case (state)
      IDLE: begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        gap_nxt   = '0;
        if (frame_start && sel && br_w) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!sel || !br_w || frame_start) begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          gap_nxt   = '0;
          if (!sel || !br_w) state_nxt = IDLE;
        end else if (bit_vld) begin
          gap_nxt = '0;
          if (cnt == CW'(WIDTH - 1)) begin
            complete  = 1'b1;
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
          end else begin
            shreg_nxt = word_nxt;
            cnt_nxt   = cnt + CW'(1);
          end
        end else if (gap == 8'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
          shreg_nxt = '0;
          cnt_nxt   = '0;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sdrd_deser.sv
// tb/tb_sdrd_deser.sv - self-checking bench for sdrd_deser
module tb_sdrd_deser;
  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst, sel, br_w, frame_start, bit_vld, sdrd_in, rd_ack;
  logic [W-1:0] data_out;
  logic         data_rdy, busy, overrun, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_data;
  logic         exp_rdy, exp_ovr, exp_to;

  sdrd_deser #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .br_w(br_w), .frame_start(frame_start),
    .bit_vld(bit_vld), .sdrd_in(sdrd_in), .rd_ack(rd_ack), .data_out(data_out),
    .data_rdy(data_rdy), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    sdrd_in = 1'($urandom);
  endtask

  task automatic pulse_start;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic pulse_ack;
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int idle, input bit ack);
    repeat (idle) tick;
    bit_vld = 1'b1;
    sdrd_in = b;
    rd_ack  = ack;
    tick;
    bit_vld = 1'b0;
    rd_ack  = 1'b0;
  endtask

  // Sends bits [hi:lo] of w, MSB first; idle < 0 picks a random legal gap per bit.
  task automatic send_bits(input logic [W-1:0] w, input int hi, input int lo,
                           input int idle, input bit ack_last);
    for (int i = hi; i >= lo; i--)
      send_bit(w[i], (idle < 0) ? int'($urandom_range(0, TO - 1)) : idle, ack_last && (i == lo));
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; br_w = 1'b0; frame_start = 1'b0;
    bit_vld = 1'b0; sdrd_in = 1'b0; rd_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++; if ({data_out, data_rdy, busy, overrun, timeout_err} !== {W'(0), 4'b0000}) begin
      errors++; $display("FAIL reset_state: got %h/%b%b%b%b expected 00/0000", data_out, data_rdy, busy, overrun, timeout_err); end
  endtask

  task automatic test_basic_frame;
    sel = 1'b1; br_w = 1'b1;
    pulse_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
    send_bits(8'hA5, 7, 1, 1, 1'b0);
    checks++; if (data_rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_before_last: got %b expected 0", data_rdy); end
    send_bits(8'hA5, 0, 0, 1, 1'b0);
    checks++; if ({data_out, data_rdy, busy, overrun, timeout_err} !== {8'hA5, 4'b1000}) begin
      errors++; $display("FAIL basic_frame: got %h/%b%b%b%b expected a5/1000", data_out, data_rdy, busy, overrun, timeout_err); end
    pulse_ack;
    checks++; if (data_rdy !== 1'b0) begin errors++; $display("FAIL basic_ack: got rdy %b expected 0", data_rdy); end
  endtask

  task automatic test_overrun;
    pulse_start; send_bits(8'h3C, 7, 0, 0, 1'b0);
    pulse_start; send_bits(8'hFF, 7, 0, 0, 1'b0);
    checks++; if ({data_out, data_rdy, overrun} !== {8'h3C, 2'b11}) begin
      errors++; $display("FAIL overrun_set: got %h/%b%b expected 3c/11", data_out, data_rdy, overrun); end
    pulse_ack;
    checks++; if ({data_out, data_rdy, overrun} !== {8'h3C, 2'b00}) begin
      errors++; $display("FAIL overrun_clear: got %h/%b%b expected 3c/00", data_out, data_rdy, overrun); end
  endtask

  task automatic test_ack_with_completion;
    pulse_start; send_bits(8'h11, 7, 0, 0, 1'b0);
    pulse_start; send_bits(8'h22, 7, 0, 0, 1'b1);
    checks++; if ({data_out, data_rdy, overrun} !== {8'h22, 2'b10}) begin
      errors++; $display("FAIL ack_with_completion: got %h/%b%b expected 22/10", data_out, data_rdy, overrun); end
    pulse_ack;
  endtask

  task automatic test_timeout;
    pulse_start; send_bits(8'hA0, 7, 5, 0, 1'b0);
    repeat (TO - 1) tick;
    checks++; if ({busy, timeout_err} !== 2'b10) begin
      errors++; $display("FAIL timeout_early: got busy/to %b%b expected 10", busy, timeout_err); end
    tick;
    checks++; if ({busy, timeout_err, data_rdy} !== 3'b010) begin
      errors++; $display("FAIL timeout_abort: got busy/to/rdy %b%b%b expected 010", busy, timeout_err, data_rdy); end
    pulse_ack;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_ack_clear: got %b expected 0", timeout_err); end
    pulse_start; send_bits(8'hB3, 7, 5, 0, 1'b0);
    send_bits(8'hB3, 4, 0, TO - 1, 1'b0);
    checks++; if ({data_out, data_rdy, busy, timeout_err} !== {8'hB3, 3'b100}) begin
      errors++; $display("FAIL timeout_bit_wins: got %h/%b%b%b expected b3/100", data_out, data_rdy, busy, timeout_err); end
  endtask

  task automatic test_abort_restart;
    pulse_start; send_bits(8'hFF, 7, 3, 0, 1'b0);
    sel = 1'b0; tick; sel = 1'b1;
    checks++; if ({data_out, data_rdy, busy, overrun, timeout_err} !== {8'hB3, 4'b1000}) begin
      errors++; $display("FAIL abort_sel: got %h/%b%b%b%b expected b3/1000", data_out, data_rdy, busy, overrun, timeout_err); end
    pulse_ack;
    pulse_start; send_bits(8'hE0, 7, 5, 0, 1'b0);
    frame_start = 1'b1; bit_vld = 1'b1; sdrd_in = 1'b1;
    tick;
    frame_start = 1'b0; bit_vld = 1'b0;
    send_bits(8'h81, 7, 0, 0, 1'b0);
    checks++; if ({data_out, data_rdy, busy, overrun} !== {8'h81, 3'b100}) begin
      errors++; $display("FAIL restart: got %h/%b%b%b expected 81/100", data_out, data_rdy, busy, overrun); end
  endtask

  task automatic test_reset_mid_frame;
    pulse_start; send_bits(8'h77, 7, 0, 0, 1'b0);
    pulse_start; send_bits(8'hFF, 7, 4, 0, 1'b0);
    rst = 1'b1; tick; rst = 1'b0;
    checks++; if ({data_out, data_rdy, busy, overrun, timeout_err} !== {W'(0), 4'b0000}) begin
      errors++; $display("FAIL reset_mid_frame: got %h/%b%b%b%b expected 00/0000", data_out, data_rdy, busy, overrun, timeout_err); end
    pulse_start; send_bits(8'h5A, 7, 0, 0, 1'b0);
    checks++; if ({data_out, data_rdy, overrun} !== {8'h5A, 2'b10}) begin
      errors++; $display("FAIL frame_after_reset: got %h/%b%b expected 5a/10", data_out, data_rdy, overrun); end
  endtask

  task automatic test_back_to_back;
    pulse_ack;
    pulse_start; send_bits(8'h69, 7, 0, 0, 1'b0);
    pulse_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_accepted: got %b expected 1", busy); end
    send_bits(8'h96, 7, 0, 0, 1'b1);
    checks++; if ({data_out, data_rdy, busy, overrun} !== {8'h96, 3'b100}) begin
      errors++; $display("FAIL back_to_back: got %h/%b%b%b expected 96/100", data_out, data_rdy, busy, overrun); end
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    int           k;
    bit           ack_last;
    rst = 1'b1; tick; rst = 1'b0;
    exp_data = '0; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_to = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack;
        exp_rdy = 1'b0; exp_ovr = 1'b0; exp_to = 1'b0;
      end
      w = W'($urandom);
      pulse_start;
      if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, W - 1));
        if (k > 0) send_bits(w, W - 1, W - k, -1, 1'b0);
        repeat (TO) tick;
        exp_to = 1'b1;
      end else begin
        ack_last = ($urandom_range(0, 3) == 0);
        send_bits(w, W - 1, 0, -1, ack_last);
        if (!exp_rdy || ack_last) begin
          exp_data = w; exp_rdy = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      checks++; if ({data_out, data_rdy, busy, overrun, timeout_err} !== {exp_data, exp_rdy, 1'b0, exp_ovr, exp_to}) begin
        errors++; $display("FAIL random_frame_%0d: got %h/%b%b%b%b expected %h/%b0%b%b", n,
                           data_out, data_rdy, busy, overrun, timeout_err, exp_data, exp_rdy, exp_ovr, exp_to); end
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_overrun;
    test_ack_with_completion;
    test_timeout;
    test_abort_restart;
    test_reset_mid_frame;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
